// File: rtl/core_pkg.sv
// Arbiter state/owner types, starvation default and word-alignment helper.
package core_pkg;
  import width_param::*;

  typedef enum logic [1:0] {IDLE, RSP_IF, RSP_MEM} arb_state_t;
  typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;

  localparam int STARVE_LIMIT_DEF = 3;

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/width_param.sv
// Bus widths shared by the core memory path.
package width_param;
  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_OF_BYTES = 4;
endpackage

// File: rtl/sram_if.sv
// Single-port synchronous SRAM: read data returns the cycle after rd_en.
interface sram_if;
  import width_param::*;

  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NUM_OF_BYTES-1:0] wr_mask;

  modport m (output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask, input rd_data);
  modport s (input rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask, output rd_data);
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between fetch and memory stage; MEM wins unless IF has starved.
// One acceptance per cycle, response exactly one cycle later; losers retry, no buffering.
module sram_port_arbiter
  import core_pkg::*;
  import width_param::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_valid,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_req_ready,
  input  logic                    if_flush,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_we,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_wdata,
  input  logic [NUM_OF_BYTES-1:0] mem_req_wmask,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  sram_if.m                       sram_io
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  arb_owner_t    w_owner;
  logic [CW-1:0] r_starve_cnt;
  logic          r_mem_we;
  logic          w_if_prio;
  logic          w_if_acc;
  logic          w_mem_acc;

  // Each ready looks only at the other requester's valid, never its own.
  assign w_if_prio     = (r_starve_cnt == LIMIT);
  assign if_req_ready  = rst_n & (w_if_prio | ~mem_req_valid);
  assign mem_req_ready = rst_n & ~(w_if_prio & if_req_valid);
  assign w_if_acc      = if_req_valid & if_req_ready;
  assign w_mem_acc     = mem_req_valid & mem_req_ready;

  always_comb begin
    sram_io.rd_en   = 1'b0;
    sram_io.rd_addr = '0;
    sram_io.wr_en   = 1'b0;
    sram_io.wr_addr = '0;
    sram_io.wr_data = '0;
    sram_io.wr_mask = '0;
    w_owner         = OWN_MEM;
    if (w_if_acc) begin
      w_owner         = OWN_IF;
      sram_io.rd_en   = 1'b1;
      sram_io.rd_addr = word_align(if_req_addr);
    end else if (w_mem_acc) begin
      if (mem_req_we) begin
        sram_io.wr_en   = 1'b1;
        sram_io.wr_addr = word_align(mem_req_addr);
        sram_io.wr_data = mem_req_wdata;
        sram_io.wr_mask = mem_req_wmask;
      end else begin
        sram_io.rd_en   = 1'b1;
        sram_io.rd_addr = word_align(mem_req_addr);
      end
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    if (w_if_acc || w_mem_acc) begin
      w_state_nxt = (w_owner == OWN_IF) ? RSP_IF : RSP_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= w_mem_acc & mem_req_we;
      if (!if_req_valid || w_if_acc) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
    end
  end

  // Gating with rst_n drops a pending response the moment reset is applied.
  assign if_rsp_valid  = rst_n & (r_state == RSP_IF) & ~if_flush;
  assign mem_rsp_valid = rst_n & (r_state == RSP_MEM);
  assign if_rsp_data   = if_rsp_valid ? sram_io.rd_data : '0;
  assign mem_rsp_data  = (mem_rsp_valid & ~r_mem_we) ? sram_io.rd_data : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a response scoreboard and SRAM model.
module tb_sram_port_arbiter;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t if_q[$];
  exp_t mem_q[$];

  sram_if sram();

  sram_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_req_ready  (if_req_ready),
    .if_flush      (if_flush),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .sram_io       (sram)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sram_val(input logic [31:0] a);
    if (a == 32'h1C00_0004) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0F0F;
  endfunction

  initial sram.rd_data = '0;
  always @(posedge clk) if (sram.rd_en) sram.rd_data <= sram_val(sram.rd_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: every response must match the head of its queue, on time.
  always @(negedge clk) begin
    exp_t e;
    if (if_rsp_valid) begin
      if (if_q.size() == 0) chk("if_rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        chk("if_rsp_cycle", cyc, e.due);
        chk("if_rsp_data", if_rsp_data, e.data);
      end
    end else begin
      chk("if_rsp_data_idle", if_rsp_data, 32'd0);
      if (if_q.size() != 0 && if_q[0].due < cyc) begin
        chk("if_rsp_missing", cyc, if_q[0].due);
        void'(if_q.pop_front());
      end
    end
    if (mem_rsp_valid) begin
      if (mem_q.size() == 0) chk("mem_rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = mem_q.pop_front();
        chk("mem_rsp_cycle", cyc, e.due);
        chk("mem_rsp_data", mem_rsp_data, e.data);
      end
    end else begin
      chk("mem_rsp_data_idle", mem_rsp_data, 32'd0);
      if (mem_q.size() != 0 && mem_q[0].due < cyc) begin
        chk("mem_rsp_missing", cyc, mem_q[0].due);
        void'(mem_q.pop_front());
      end
    end
  end

  // Drives one cycle, checks acceptance and the SRAM port, queues expected responses.
  task automatic do_cycle(input logic ifv, input logic [31:0] ifa,
                          input logic memv, input logic we, input logic [31:0] mema,
                          input logic [31:0] wd, input logic [3:0] wm, input logic flush,
                          input logic eia, input logic ema, input logic push_if);
    logic        e_rd;
    logic [31:0] e_rd_addr;
    logic        e_wr;
    exp_t        e;
    if_req_valid  = ifv;  if_req_addr   = ifa;  if_flush = flush;
    mem_req_valid = memv; mem_req_we    = we;   mem_req_addr = mema;
    mem_req_wdata = wd;   mem_req_wmask = wm;
    e_rd      = eia || (ema && !we);
    e_rd_addr = eia ? (ifa & ~32'h3) : ((ema && !we) ? (mema & ~32'h3) : 32'h0);
    e_wr      = ema && we;
    @(negedge clk);
    chk("if_accept", {31'd0, ifv && if_req_ready}, {31'd0, eia});
    chk("mem_accept", {31'd0, memv && mem_req_ready}, {31'd0, ema});
    chk("sram_rd_en", {31'd0, sram.rd_en}, {31'd0, e_rd});
    chk("sram_rd_addr", sram.rd_addr, e_rd_addr);
    chk("sram_wr_en", {31'd0, sram.wr_en}, {31'd0, e_wr});
    chk("sram_wr_addr", sram.wr_addr, e_wr ? (mema & ~32'h3) : 32'h0);
    chk("sram_wr_data", sram.wr_data, e_wr ? wd : 32'h0);
    chk("sram_wr_mask", {28'd0, sram.wr_mask}, e_wr ? {28'd0, wm} : 32'h0);
    if (eia && push_if) begin
      e.due = cyc + 1; e.data = sram_val(ifa & ~32'h3);
      if_q.push_back(e);
    end
    if (ema) begin
      e.due = cyc + 1; e.data = we ? 32'h0 : sram_val(mema & ~32'h3);
      mem_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_valid = 0; if_req_addr = 0; if_flush = 0;
    mem_req_valid = 0; mem_req_we = 0; mem_req_addr = 0; mem_req_wdata = 0; mem_req_wmask = 0;
    repeat (2) @(posedge clk);
    #1;
    // Requests under reset must see no ready and no SRAM activity.
    do_cycle(1, 32'h0000_0010, 1, 1, 32'h0000_0020, 32'h1, 4'hF, 0, 0, 0, 0);
    rst_n = 1'b1;

    if_req_valid = 0; mem_req_valid = 0;
    @(negedge clk);
    chk("idle_if_ready", {31'd0, if_req_ready}, 32'd1);
    chk("idle_mem_ready", {31'd0, mem_req_ready}, 32'd1);
    @(posedge clk); #1;

    do_cycle(1, 32'h1C00_0004, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle();
    do_cycle(0, 0, 1, 1, 32'h0000_1002, 32'h00AB_0000, 4'b0100, 0, 0, 1, 0);
    idle();

    // Back-to-back MEM load, IF (unaligned), MEM store.
    do_cycle(0, 0, 1, 0, 32'h0000_2008, 0, 0, 0, 0, 1, 0);
    do_cycle(1, 32'h0000_300E, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    do_cycle(0, 0, 1, 1, 32'h0000_4001, 32'h1122_3344, 4'hF, 0, 0, 1, 0);
    idle();

    // Continuous contention: MEM x3, IF, repeating.
    for (int i = 0; i < 8; i++)
      do_cycle(1, 32'h0000_5000, 1, 0, 32'h0000_6000, 0, 0, 0, (i % 4) == 3, (i % 4) != 3, 1);
    idle();

    // IF dropping valid clears the starvation count.
    for (int i = 0; i < 2; i++)
      do_cycle(1, 32'h0000_5100, 1, 0, 32'h0000_6100, 0, 0, 0, 0, 1, 1);
    do_cycle(0, 0, 1, 0, 32'h0000_6200, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      do_cycle(1, 32'h0000_5300, 1, 0, 32'h0000_6300, 0, 0, 0, i == 3, i != 3, 1);
    idle();

    // Flush discards the pending fetch but a new fetch is still accepted.
    do_cycle(1, 32'h0000_7000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle(1, 32'h0000_7004, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    idle();

    // Reset with a fetch response pending, then starvation count restarts from 0.
    do_cycle(1, 32'h0000_8000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    do_cycle(1, 32'h0000_8004, 1, 0, 32'h0000_9000, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++)
      do_cycle(1, 32'h0000_A000, 1, 0, 32'h0000_B000, 0, 0, 0, i == 3, i != 3, 1);

    repeat (3) idle();
    chk("if_queue_drained", if_q.size(), 32'd0);
    chk("mem_queue_drained", mem_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
